axis_pkt_fifo: RTL

- Store-and-forward packet FIFO placed directly downstream of the ADC-to-UDP framer, feeding the 10G Ethernet MAC TX AXIS port.
- Buffers complete UDP frames and releases a frame only once its last beat has been written, so the MAC never sees tvalid drop mid-frame.
- A frame that cannot fit is discarded whole. Overflows are counted, never stalled back into the framer.

---
 rtl/axis_pkt_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXIS packet FIFO, lossy on overflow.
// Optional build macro PKT_FIFO_STATS_EN enables drop_count / tx_count.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = 8,
    parameter int DEPTH_LOG2    = 9,
    parameter int PKT_CNT_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s00_axis_tkeep,
    input  logic                  s00_axis_tlast,
    input  logic                  s00_axis_tuser,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tuser,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic                  overflow,
    output logic [31:0]           drop_count,
    output logic [31:0]           tx_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    // Packet counter is widened if needed so DEPTH one-beat frames never wrap it
    localparam int CW    = (PKT_CNT_WIDTH > PW) ? PKT_CNT_WIDTH : PW;
    localparam int MW    = DATA_WIDTH + KEEP_WIDTH + 2;

    if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_keep_chk
        $error("axis_pkt_fifo: KEEP_WIDTH must equal DATA_WIDTH/8");
    end

    typedef enum logic {
        WRITE,
        DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SEND
    } rd_state_t;

    logic [MW-1:0]         mem [DEPTH];
    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         commit_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_inc;
    logic [PW-1:0]         rd_ptr_inc;
    logic [PW-1:0]         fill;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [CW-1:0]         pkt_cnt;
    logic [CW-1:0]         pkt_cnt_nxt;
    logic                  beat;
    logic                  full;
    logic                  wr_en;
    logic                  commit;
    logic                  drop_evt;
    logic                  tx_hs;
    logic                  tx_done;

    // Never back-pressure the framer; only hold it off during reset
    assign s00_axis_tready = ~areset;

    assign beat       = s00_axis_tvalid & ~areset;
    assign fill       = wr_ptr - rd_ptr;
    assign full       = (fill == PW'(DEPTH));
    assign wr_ptr_inc = wr_ptr + PW'(1);
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign wr_en      = beat & (wr_state == WRITE) & ~full;
    assign commit     = wr_en & s00_axis_tlast;
    assign drop_evt   = beat & s00_axis_tlast
                      & ((wr_state == DROP) | full);

    assign tx_hs       = m00_axis_tvalid & m00_axis_tready;
    assign tx_done     = tx_hs & m00_axis_tlast;
    assign pkt_cnt_nxt = pkt_cnt + CW'(commit) - CW'(tx_done);

    // In SEND the next beat is fetched ahead so tvalid never gaps mid-frame
    assign rd_idx = (rd_state == SEND) ? rd_ptr_inc[DEPTH_LOG2-1:0]
                                       : rd_ptr[DEPTH_LOG2-1:0];

    // Beat storage: {tuser, tlast, tkeep, tdata}
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s00_axis_tuser, s00_axis_tlast,
                                            s00_axis_tkeep, s00_axis_tdata};
        end
    end

    // Write side: accept beats, commit on tlast, rewind a frame that overflows
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state   <= WRITE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop_evt;
            if (drop_evt) begin
                wr_ptr   <= commit_ptr;
                wr_state <= WRITE;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr_inc;
                if (s00_axis_tlast) begin
                    commit_ptr <= wr_ptr_inc;
                end
            end else if (beat & full) begin
                wr_state <= DROP;
            end
        end
    end

    // Read side: prime the output register, then stream one committed frame
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state        <= IDLE;
            rd_ptr          <= '0;
            pkt_cnt         <= '0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
            m00_axis_tvalid <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt_nxt;
            unique case (rd_state)
                IDLE: begin
                    if (pkt_cnt != '0) begin
                        rd_state <= PRIME;
                    end
                end
                PRIME: begin
                    {m00_axis_tuser, m00_axis_tlast,
                     m00_axis_tkeep, m00_axis_tdata} <= mem[rd_idx];
                    m00_axis_tvalid <= 1'b1;
                    rd_state        <= SEND;
                end
                SEND: begin
                    if (tx_hs) begin
                        rd_ptr <= rd_ptr_inc;
                        if (m00_axis_tlast) begin
                            m00_axis_tvalid <= 1'b0;
                            rd_state <= (pkt_cnt_nxt != '0) ? PRIME : IDLE;
                        end else begin
                            {m00_axis_tuser, m00_axis_tlast,
                             m00_axis_tkeep, m00_axis_tdata} <= mem[rd_idx];
                        end
                    end
                end
                default: begin
                    rd_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PKT_FIFO_STATS_EN
    logic [31:0] drop_q;
    logic [31:0] tx_q;

    // Wrapping frame statistics
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_q <= '0;
            tx_q   <= '0;
        end else begin
            if (drop_evt) begin
                drop_q <= drop_q + 32'd1;
            end
            if (tx_done) begin
                tx_q <= tx_q + 32'd1;
            end
        end
    end

    assign drop_count = drop_q;
    assign tx_count   = tx_q;
`else
    assign drop_count = '0;
    assign tx_count   = '0;
`endif

endmodule
